// File: rtl/driver_pkg.sv
// Shared constants, state type and bit-index helper for the LED driver transmit path.
package driver_pkg;

  localparam int NB_DRIVERS     = 15;
  localparam int BITS_PER_PLANE = 48;
  localparam int NB_PLANES      = 9;
  localparam int FRAME_W        = NB_PLANES * BITS_PER_PLANE;
  localparam int WRTGS_LAT_LEN  = 1;
  localparam int LATGS_LAT_LEN  = 3;

  localparam int PLANE_W = 4;
  localparam int BIT_W   = 6;
  localparam int GAP_W   = 4;
  localparam int IDX_W   = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } drv_state_e;

  // Bit position inside a driver's frame word for plane p and bit counter k
  // (counter k walks the plane MSB first, so it addresses local bit 47-k).
  function automatic logic [IDX_W-1:0] frame_bit_index(input logic [PLANE_W-1:0] plane,
                                                       input logic [BIT_W-1:0]   k);
    return IDX_W'(plane) * IDX_W'(BITS_PER_PLANE)
         + IDX_W'(BITS_PER_PLANE - 1) - IDX_W'(k);
  endfunction

endpackage

// File: rtl/driver_lat_gen.sv
// Decodes the driver LAT level from the serializer position: a short WRTGS
// pulse at the tail of planes 8..1 and a longer LATGS pulse at the tail of plane 0.
module driver_lat_gen
  import driver_pkg::*;
(
  input  logic [1:0]         state,
  input  logic [PLANE_W-1:0] plane,
  input  logic [BIT_W-1:0]   k,
  output logic               lat
);

  // LAT is asserted only while shifting and only over the last few bits of a plane.
  always_comb begin
    lat = 1'b0;
    if (state == SHIFT) begin
      if (plane == PLANE_W'(0)) begin
        lat = (k >= BIT_W'(BITS_PER_PLANE - LATGS_LAT_LEN));
      end else begin
        lat = (k >= BIT_W'(BITS_PER_PLANE - WRTGS_LAT_LEN));
      end
    end else begin
      lat = 1'b0;
    end
  end

endmodule

// File: rtl/driver_serializer.sv
// Captures one remapped frame and shifts it, plane 8 down to plane 0, MSB first,
// into 15 parallel TLC5957 drivers with shared SCLK and LAT.
module driver_serializer
  import driver_pkg::*;
#(
  parameter int GAP_CYCLES = 2
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FRAME_W-1:0]    frame_data [NB_DRIVERS-1:0],
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic                  busy,
  output logic                  drv_sclk,
  output logic                  drv_lat,
  output logic [NB_DRIVERS-1:0] drv_sin
);

  drv_state_e           state_r, state_nxt_s;
  logic [PLANE_W-1:0]   plane_r, plane_nxt_s;
  logic [BIT_W-1:0]     k_r, k_nxt_s;
  logic                 phase_r, phase_nxt_s;
  logic [GAP_W-1:0]     gap_r, gap_nxt_s;
  logic [FRAME_W-1:0]   buf_r [NB_DRIVERS-1:0];

  logic                 accept_s;
  logic [IDX_W-1:0]     bit_idx_s;
  logic [NB_DRIVERS-1:0] sin_nxt_s;
  logic                 sclk_nxt_s;
  logic                 lat_nxt_s;

  logic                 drv_sclk_r;
  logic                 drv_lat_r;
  logic [NB_DRIVERS-1:0] drv_sin_r;

  assign frame_ready = (state_r == IDLE) && !rst;
  assign busy        = (state_r != IDLE);
  assign accept_s    = frame_valid && frame_ready;

  assign drv_sclk = drv_sclk_r;
  assign drv_lat  = drv_lat_r;
  assign drv_sin  = drv_sin_r;

  // Next position in the frame: phase toggles every cycle, k steps after phase 1,
  // a gap follows each plane and the frame ends after plane 0's gap.
  always_comb begin
    state_nxt_s = state_r;
    plane_nxt_s = plane_r;
    k_nxt_s     = k_r;
    phase_nxt_s = phase_r;
    gap_nxt_s   = gap_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = SHIFT;
          plane_nxt_s = PLANE_W'(NB_PLANES - 1);
          k_nxt_s     = BIT_W'(0);
          phase_nxt_s = 1'b0;
          gap_nxt_s   = GAP_W'(0);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (!phase_r) begin
          phase_nxt_s = 1'b1;
        end else if (k_r == BIT_W'(BITS_PER_PLANE - 1)) begin
          state_nxt_s = GAP;
          phase_nxt_s = 1'b0;
          gap_nxt_s   = GAP_W'(0);
        end else begin
          k_nxt_s     = k_r + BIT_W'(1);
          phase_nxt_s = 1'b0;
        end
      end
      GAP: begin
        if (gap_r == GAP_W'(GAP_CYCLES - 1)) begin
          if (plane_r == PLANE_W'(0)) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = SHIFT;
            plane_nxt_s = plane_r - PLANE_W'(1);
            k_nxt_s     = BIT_W'(0);
            phase_nxt_s = 1'b0;
          end
        end else begin
          gap_nxt_s = gap_r + GAP_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign bit_idx_s  = frame_bit_index(plane_nxt_s, k_nxt_s);
  assign sclk_nxt_s = (state_nxt_s == SHIFT) && phase_nxt_s;

  // Serial data for the upcoming cycle; on the accept edge the bit comes straight
  // from the incoming frame since the buffer is only loaded at that same edge.
  always_comb begin
    sin_nxt_s = {NB_DRIVERS{1'b0}};
    for (int i = 0; i < NB_DRIVERS; i++) begin
      if (state_nxt_s == SHIFT) begin
        if (accept_s) begin
          sin_nxt_s[i] = frame_data[i][bit_idx_s];
        end else begin
          sin_nxt_s[i] = buf_r[i][bit_idx_s];
        end
      end else begin
        sin_nxt_s[i] = 1'b0;
      end
    end
  end

  driver_lat_gen u_lat_gen (
    .state (state_nxt_s),
    .plane (plane_nxt_s),
    .k     (k_nxt_s),
    .lat   (lat_nxt_s)
  );

  // Sequencer state and counters; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      plane_r <= PLANE_W'(0);
      k_r     <= BIT_W'(0);
      phase_r <= 1'b0;
      gap_r   <= GAP_W'(0);
    end else begin
      state_r <= state_nxt_s;
      plane_r <= plane_nxt_s;
      k_r     <= k_nxt_s;
      phase_r <= phase_nxt_s;
      gap_r   <= gap_nxt_s;
    end
  end

  // Registered driver pins so no input reaches a pin combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      drv_sclk_r <= 1'b0;
      drv_lat_r  <= 1'b0;
      drv_sin_r  <= {NB_DRIVERS{1'b0}};
    end else begin
      drv_sclk_r <= sclk_nxt_s;
      drv_lat_r  <= lat_nxt_s;
      drv_sin_r  <= sin_nxt_s;
    end
  end

  // Frame buffer, loaded only on an accepted frame; contents after reset are irrelevant.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      buf_r <= frame_data;
    end
  end

endmodule

// File: tb/tb_driver_serializer.sv
// Directed bench with an SCLK-edge scoreboard for driver_serializer.
module tb_driver_serializer;
  import driver_pkg::*;

  localparam int GAP       = 2;
  localparam int PLANE_CYC = 2 * BITS_PER_PLANE + GAP;
  localparam int FRAME_CYC = NB_PLANES * PLANE_CYC;

  typedef struct packed {
    logic [31:0]           stamp;
    logic                  lat;
    logic [NB_DRIVERS-1:0] sin;
  } edge_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [FRAME_W-1:0]    fd [NB_DRIVERS-1:0];
  logic                  frame_valid;
  logic                  frame_ready;
  logic                  busy;
  logic                  drv_sclk;
  logic                  drv_lat;
  logic [NB_DRIVERS-1:0] drv_sin;

  int    edge_cnt = 0;
  int    lat_cyc  = 0;
  logic  prev_sclk = 1'b0;
  edge_t cap_q [$];
  edge_t exp_q [$];
  int    rd       = 0;
  int    lat_exp  = 0;
  int    lat_base = 0;
  int    total    = 0;
  int    bad      = 0;

  driver_serializer #(.GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_data  (fd),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy),
    .drv_sclk    (drv_sclk),
    .drv_lat     (drv_lat),
    .drv_sin     (drv_sin)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number e the value is e.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Deserializer: record SIN/LAT and time of every SCLK rise, count LAT-high cycles.
  always @(negedge clk) begin
    prev_sclk <= drv_sclk;
    if (drv_sclk && !prev_sclk) cap_q.push_back({32'(edge_cnt), drv_lat, drv_sin});
    if (drv_lat) lat_cyc <= lat_cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] lfsr_word(input int seed);
    logic [31:0]        s;
    logic [FRAME_W-1:0] w;
    s = 32'h1234_5678 ^ (32'(seed) * 32'h9E37_79B9);
    if (s == 32'h0) s = 32'h1;
    w = {FRAME_W{1'b0}};
    for (int b = 0; b < FRAME_W; b++) begin
      s    = {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
      w[b] = s[0];
    end
    return w;
  endfunction

  // Expected SCLK edges of a frame accepted at edge t, limited to stamps below cutoff.
  task automatic push_frame(input int t, input int cutoff);
    edge_t e;
    int    p;
    int    st;
    for (int n = 0; n < NB_PLANES; n++) begin
      p = NB_PLANES - 1 - n;
      for (int k = 0; k < BITS_PER_PLANE; k++) begin
        st = t + 1 + n * PLANE_CYC + 2 * k;
        if (st < cutoff) begin
          e.stamp = 32'(st);
          e.lat   = (p == 0) ? (k >= 45) : (k == 47);
          for (int i = 0; i < NB_DRIVERS; i++) e.sin[i] = fd[i][48 * p + 47 - k];
          exp_q.push_back(e);
          if (e.lat) lat_exp += 2;
        end
      end
    end
  endtask

  task automatic sb_check(input string tag);
    edge_t e;
    bit    short_s;
    short_s = 1'b0;
    while (exp_q.size() != 0 && !short_s) begin
      e = exp_q.pop_front();
      total++;
      assert (rd < cap_q.size()) else begin
        bad++;
        short_s = 1'b1;
        $error("FAIL %s_missing observed_edges=%0d expected_more_than=%0d", tag, cap_q.size(), rd);
      end
      if (!short_s) begin
        check(tag, 64'(cap_q[rd]), 64'(e));
        rd++;
      end
    end
    exp_q.delete();
    check({tag, "_extra_edges"}, 64'(cap_q.size()), 64'(rd));
    check({tag, "_lat_cycles"}, 64'(lat_cyc - lat_base), 64'(lat_exp));
    rd       = cap_q.size();
    lat_base = lat_cyc;
    lat_exp  = 0;
  endtask

  task automatic wait_until(input int e);
    while (edge_cnt < e) @(negedge clk);
  endtask

  // Offer a frame at the current negedge; returns the accept edge index.
  task automatic send_frame(output int t);
    frame_valid = 1'b1;
    @(negedge clk);
    t = edge_cnt;
    frame_valid = 1'b0;
  endtask

  initial begin
    int t;
    int t2;
    // 1: reset with frame_valid high -> nothing captured
    rst = 1'b1;
    frame_valid = 1'b1;
    for (int i = 0; i < NB_DRIVERS; i++) fd[i] = lfsr_word(50 + i);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    frame_valid = 1'b0;
    #1;
    check("rst_sclk", 64'(drv_sclk), 64'(0));
    check("rst_lat", 64'(drv_lat), 64'(0));
    check("rst_sin", 64'(drv_sin), 64'(0));
    check("rst_ready", 64'(frame_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    check("rst_no_capture_busy", 64'(busy), 64'(0));
    check("rst_no_edges", 64'(cap_q.size()), 64'(0));
    lat_base = lat_cyc;

    // 2: single bit in driver 0, plane 0 bit 0
    for (int i = 0; i < NB_DRIVERS; i++) fd[i] = {FRAME_W{1'b0}};
    fd[0][0] = 1'b1;
    send_frame(t);
    push_frame(t, t + 10000);
    check("single_busy_on", 64'(busy), 64'(1));
    wait_until(t + FRAME_CYC - 1);
    #1;
    check("single_busy_before_end", 64'(busy), 64'(1));
    @(negedge clk);
    #1;
    check("single_busy_end", 64'(busy), 64'(0));
    check("single_ready_end", 64'(frame_ready), 64'(1));
    sb_check("single");

    // 3: all-ones frame, LAT pattern
    for (int i = 0; i < NB_DRIVERS; i++) fd[i] = {FRAME_W{1'b1}};
    send_frame(t);
    push_frame(t, t + 10000);
    wait_until(t + FRAME_CYC + 2);
    sb_check("ones");

    // 4: distinct pseudo-random word per driver
    for (int i = 0; i < NB_DRIVERS; i++) fd[i] = lfsr_word(i + 1);
    send_frame(t);
    push_frame(t, t + 10000);
    wait_until(t + FRAME_CYC + 2);
    sb_check("lfsr");

    // 5: backpressure, second frame held valid from the cycle after accept
    for (int i = 0; i < NB_DRIVERS; i++) fd[i] = lfsr_word(30 + i);
    frame_valid = 1'b1;
    @(negedge clk);
    t = edge_cnt;
    push_frame(t, t + 10000);
    for (int i = 0; i < NB_DRIVERS; i++) fd[i] = lfsr_word(70 + i);
    wait_until(t + FRAME_CYC);
    #1;
    check("bp_ready_at_end", 64'(frame_ready), 64'(1));
    t2 = t + FRAME_CYC + 1;
    push_frame(t2, t2 + 10000);
    @(negedge clk);
    frame_valid = 1'b0;
    #1;
    check("bp_second_busy", 64'(busy), 64'(1));
    wait_until(t2 + FRAME_CYC + 2);
    sb_check("backpressure");

    // 6: reset during plane 4, k=20, then a fresh frame
    for (int i = 0; i < NB_DRIVERS; i++) fd[i] = lfsr_word(100 + i);
    send_frame(t);
    push_frame(t, t + 1 + 4 * PLANE_CYC + 40);
    wait_until(t + 4 * PLANE_CYC + 40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_sclk", 64'(drv_sclk), 64'(0));
    check("abort_lat", 64'(drv_lat), 64'(0));
    check("abort_sin", 64'(drv_sin), 64'(0));
    check("abort_ready", 64'(frame_ready), 64'(1));
    check("abort_busy", 64'(busy), 64'(0));
    repeat (200) @(negedge clk);
    sb_check("abort");
    for (int i = 0; i < NB_DRIVERS; i++) fd[i] = lfsr_word(200 + i);
    send_frame(t);
    push_frame(t, t + 10000);
    wait_until(t + FRAME_CYC + 2);
    sb_check("after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/driver_serializer.md
Name: driver_serializer

Overview:
- Transmit end of the LED-driver data path. Captures one remapped frame: 15 drivers × 432 bits, i.e. 9 bit-planes of 48 bits per driver.
- Shifts the frame into the 15 daisy-chain-free TLC5957 drivers over 15 parallel SIN lines, one shared SCLK and one shared LAT.
- Generates WRTGS at the end of each plane and LATGS at the end of the frame.
- Sits between the colour remap stage and the FPGA driver pins.

Parameters:
- GAP_CYCLES, 2, idle clk cycles between planes (SCLK low, LAT low, SIN held 0); range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_data  in  [431:0] x [14:0] (unpacked, index = driver)  remapped frame; bits 48*p+47..48*p form plane p
- frame_valid  in  1  frame_data valid
- frame_ready  out  1  block can accept a frame
- busy  out  1  frame in flight
- drv_sclk  out  1  driver shift clock
- drv_lat  out  1  driver latch/command line
- drv_sin  out  15  serial data, bit i to driver i

Behaviour:
- Reset (clk edge with rst=1):
  - State goes to IDLE.
  - drv_sclk=0, drv_lat=0, drv_sin=0, busy=0, frame_ready=1 from the following cycle.
  - Any frame in flight is aborted; buffer contents become don't-care.
- Accept:
  - A frame is accepted on any clk edge with frame_valid && frame_ready.
  - All 15×432 bits are copied into an internal buffer at that edge.
  - frame_ready=1 only in IDLE. frame_valid outside IDLE is ignored; no capture and no side effect.
- States:
  - IDLE → SHIFT on accept.
  - SHIFT → GAP after bit 47 phase 1.
  - GAP → SHIFT (next plane) after GAP_CYCLES cycles.
  - GAP → IDLE after the final plane's gap.
- Order:
  - Planes are sent 8 down to 0.
  - Within a plane, bits are sent MSB first: local bit 47 first, bit 0 last.
  - Bit counter k = 0..47 corresponds to local bit 47-k.
- Bit timing: each bit occupies 2 clk cycles.
  - Phase 0: drv_sin[i] = buffer[i][48*p+47-k], drv_sclk=0.
  - Phase 1: drv_sin unchanged, drv_sclk=1.
  - SIN is therefore stable one full clk on each side of the SCLK rising edge.
- LAT window:
  - Planes 8..1 (WRTGS): drv_lat=1 during both phases of k=47 only.
  - Plane 0 (LATGS): drv_lat=1 during both phases of k=45,46,47.
  - drv_lat=0 in GAP and IDLE.
- Timing (accept edge at cycle T):
  - First phase 0 is at T+1; first SCLK high is at T+2.
  - Plane n (0-based send order) starts at T+1+n*(96+GAP_CYCLES).
  - Back in IDLE at T+1+9*(96+GAP_CYCLES); 883 with the default.
  - Exactly 432 SCLK rising edges per frame.
- busy = (state != IDLE). frame_ready = !busy && !rst.
- All outputs are registered. No combinational path from inputs to drv_* pins.
- Simultaneous rst and frame_valid: reset wins, no capture.

Decomposition:
- Shared package (driver_pkg), constants:
  - NB_DRIVERS=15, BITS_PER_PLANE=48, NB_PLANES=9
  - FRAME_W=432 (= NB_PLANES*BITS_PER_PLANE)
  - WRTGS_LAT_LEN=1, LATGS_LAT_LEN=3
- Shared package, typedef: the state enum {IDLE, SHIFT, GAP}.
- One natural sub-module, driver_lat_gen: combinational decode of (state, plane, k) to the LAT level, reused by future driver-config write logic (FCWRTEN, 15-edge LAT).
- Counters (plane, k, phase, gap) and the buffer stay in the top.

Test Plan:
1. rst=1 for 2 cycles with frame_valid=1 → no capture; after release drv_sclk=0, drv_lat=0, drv_sin=0, frame_ready=1, busy=0.
2. Single frame, frame_data[0]=432'h1, all others 0, accepted at T:
   - drv_sin[0]=1 only at cycles T+879..T+880 (plane 0, k=47).
   - drv_sin[14:1]=0 throughout.
   - Exactly 432 drv_sclk rising edges.
   - busy falls and frame_ready=1 at T+883.
3. LAT pattern, all-ones frame:
   - LAT high at SCLK rising edges 48, 96, …, 384 (one per plane for planes 8..1).
   - LAT high at edges 430, 431, 432 (plane 0).
   - 11 LAT-high rising edges total; LAT low during every gap.
4. Per-driver independence: frame_data[i] = distinct 432-bit LFSR word seeded by i → a bench deserializer sampling drv_sin[i] on SCLK rise reconstructs every frame_data[i] exactly.
5. Backpressure: frame_valid held high with a second, different frame from T+1 → ignored until T+883; second frame accepted at T+883; its first SCLK high at T+885; the first frame's output is unaffected.
6. rst asserted for one cycle mid-plane 4, k=20 → next cycle all drv_* = 0 and frame_ready=1; no further SCLK edges until a new accept; a new frame afterwards streams correctly from plane 8, bit 47.
